// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller and its datapath.
// Signals: op, mem_ready (datapath -> controller); pcwrite, memwrite, irwrite,
// regwrite, alusrca, branch, iord, memtoreg, regdst, linkwrite, alusrcb, pcsrc,
// aluop, illegal, state (controller -> datapath).
// Modports: master = controller side, slave = datapath side.
interface multicycle_controller_if #(
  parameter int unsigned OPW = 4
);
  logic [OPW-1:0] op;
  logic           mem_ready;
  logic           pcwrite;
  logic           memwrite;
  logic           irwrite;
  logic           regwrite;
  logic           alusrca;
  logic           branch;
  logic           iord;
  logic           memtoreg;
  logic           regdst;
  logic           linkwrite;
  logic [1:0]     alusrcb;
  logic [1:0]     pcsrc;
  logic [1:0]     aluop;
  logic           illegal;
  logic [3:0]     state;

  modport master (
    input  op, mem_ready,
    output pcwrite, memwrite, irwrite, regwrite, alusrca, branch, iord,
           memtoreg, regdst, linkwrite, alusrcb, pcsrc, aluop, illegal, state
  );

  modport slave (
    output op, mem_ready,
    input  pcwrite, memwrite, irwrite, regwrite, alusrca, branch, iord,
           memtoreg, regdst, linkwrite, alusrcb, pcsrc, aluop, illegal, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle control FSM: sequences fetch/decode/memory/ALU/branch/jump steps
// and decodes every datapath enable and mux select from the current state.
// Ports: clk, reset (async, active-low), bus (multicycle_controller_if.master).
// Optional feature macro: MCCTRL_MEMWAIT_EN -- FETCH, MEMRD and MEMWR stall
// until mem_ready; without it mem_ready is ignored and every state is 1 cycle.
module multicycle_controller #(
  parameter int unsigned    OPW     = 4,
  parameter logic [OPW-1:0] OP_ADD  = OPW'(4'b0000),
  parameter logic [OPW-1:0] OP_NAND = OPW'(4'b0010),
  parameter logic [OPW-1:0] OP_SW   = OPW'(4'b1001),
  parameter logic [OPW-1:0] OP_LW   = OPW'(4'b1010),
  parameter logic [OPW-1:0] OP_BEQ  = OPW'(4'b1011),
  parameter logic [OPW-1:0] OP_JAL  = OPW'(4'b1101)
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_TRAP    = 4'd10
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_illegal;
  logic       w_ready;
  logic       w_pcwrite, w_memwrite, w_irwrite, w_regwrite, w_alusrca;
  logic       w_branch, w_iord, w_memtoreg, w_regdst, w_linkwrite;
  logic [1:0] w_alusrcb, w_pcsrc, w_aluop;

`ifdef MCCTRL_MEMWAIT_EN
  assign w_ready = bus.mem_ready;
`else
  logic w_unused_mem_ready;
  assign w_ready            = 1'b1;
  assign w_unused_mem_ready = bus.mem_ready;
`endif

  // State register; reset forces FETCH immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Trap flag is set on the edge that enters TRAP and only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                r_illegal <= 1'b0;
    else if (w_next == S_TRAP) r_illegal <= 1'b1;
  end

  // Next-state and control decode.
  always_comb begin
    w_next      = S_FETCH;
    w_pcwrite   = 1'b0;
    w_memwrite  = 1'b0;
    w_irwrite   = 1'b0;
    w_regwrite  = 1'b0;
    w_alusrca   = 1'b0;
    w_branch    = 1'b0;
    w_iord      = 1'b0;
    w_memtoreg  = 1'b0;
    w_regdst    = 1'b0;
    w_linkwrite = 1'b0;
    w_alusrcb   = 2'b00;
    w_pcsrc     = 2'b00;
    w_aluop     = 2'b00;
    case (r_state)
      S_DECODE: begin
        w_alusrcb = 2'b11;
        if      (bus.op == OP_LW || bus.op == OP_SW)    w_next = S_MEMADR;
        else if (bus.op == OP_ADD || bus.op == OP_NAND) w_next = S_EXECUTE;
        else if (bus.op == OP_BEQ)                      w_next = S_BRANCH;
        else if (bus.op == OP_JAL)                      w_next = S_JUMP;
        else                                            w_next = S_TRAP;
      end
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        if      (bus.op == OP_LW) w_next = S_MEMRD;
        else if (bus.op == OP_SW) w_next = S_MEMWR;
        else                      w_next = S_TRAP;
      end
      S_MEMRD: begin
        w_iord = 1'b1;
        w_next = w_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        w_regwrite = 1'b1;
        w_memtoreg = 1'b1;
      end
      S_MEMWR: begin
        // Write strobe stays up for the whole memory wait.
        w_memwrite = 1'b1;
        w_iord     = 1'b1;
        w_next     = w_ready ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b10;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        w_regwrite = 1'b1;
        w_regdst   = 1'b1;
      end
      S_BRANCH: begin
        w_alusrca = 1'b1;
        w_branch  = 1'b1;
        w_pcsrc   = 2'b01;
        w_aluop   = 2'b01;
      end
      S_JUMP: begin
        w_pcwrite   = 1'b1;
        w_regwrite  = 1'b1;
        w_linkwrite = 1'b1;
        w_pcsrc     = 2'b10;
      end
      S_TRAP: begin
        w_next = S_TRAP;
      end
      default: begin
        // FETCH and any unused code: commit PC/IR only when memory is ready.
        w_pcwrite = w_ready;
        w_irwrite = w_ready;
        w_alusrcb = 2'b01;
        w_next    = w_ready ? S_DECODE : S_FETCH;
      end
    endcase
  end

  assign bus.pcwrite   = w_pcwrite;
  assign bus.memwrite  = w_memwrite;
  assign bus.irwrite   = w_irwrite;
  assign bus.regwrite  = w_regwrite;
  assign bus.alusrca   = w_alusrca;
  assign bus.branch    = w_branch;
  assign bus.iord      = w_iord;
  assign bus.memtoreg  = w_memtoreg;
  assign bus.regdst    = w_regdst;
  assign bus.linkwrite = w_linkwrite;
  assign bus.alusrcb   = w_alusrcb;
  assign bus.pcsrc     = w_pcsrc;
  assign bus.aluop     = w_aluop;
  assign bus.illegal   = r_illegal;
  assign bus.state     = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction state paths
// and the per-state control table are built from the instruction rules, then
// compared cycle by cycle with random opcode noise and random mem_ready.
module tb_multicycle_controller;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_NAND = 4'b0010;
  localparam logic [3:0] OP_SW   = 4'b1001;
  localparam logic [3:0] OP_LW   = 4'b1010;
  localparam logic [3:0] OP_BEQ  = 4'b1011;
  localparam logic [3:0] OP_JAL  = 4'b1101;

  logic clk = 1'b0;
  logic reset;

  multicycle_controller_if #(.OPW(4)) bus ();

  multicycle_controller #(.OPW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  bit   exp_ill;
  bit   rnd_mode;
  logic cur_rdy;
  int   rq[$];
  int   path[$];

  // Control word order: pcwrite memwrite irwrite regwrite alusrca branch iord
  // memtoreg regdst linkwrite | alusrcb | pcsrc | aluop
  function automatic logic [15:0] exp_ctrl(input int st, input logic rdy);
    logic pw, mw, iw, rw, asa, br, io, mtr, rd, lk;
    logic [1:0] sb, ps, ao;
    logic g;
    {pw, mw, iw, rw, asa, br, io, mtr, rd, lk} = 10'b0;
    sb = 2'b00; ps = 2'b00; ao = 2'b00;
`ifdef MCCTRL_MEMWAIT_EN
    g = rdy;
`else
    g = 1'b1;
`endif
    case (st)
      0:  begin pw = g; iw = g; sb = 2'b01; end
      1:  sb = 2'b11;
      2:  begin asa = 1'b1; sb = 2'b10; end
      3:  io = 1'b1;
      4:  begin rw = 1'b1; mtr = 1'b1; end
      5:  begin mw = 1'b1; io = 1'b1; end
      6:  begin asa = 1'b1; ao = 2'b10; end
      7:  begin rw = 1'b1; rd = 1'b1; end
      8:  begin asa = 1'b1; br = 1'b1; ps = 2'b01; ao = 2'b01; end
      9:  begin pw = 1'b1; rw = 1'b1; lk = 1'b1; ps = 2'b10; end
      default: ;
    endcase
    return {pw, mw, iw, rw, asa, br, io, mtr, rd, lk, sb, ps, ao};
  endfunction

  function automatic logic [15:0] obs_ctrl();
    return {bus.pcwrite, bus.memwrite, bus.irwrite, bus.regwrite, bus.alusrca,
            bus.branch, bus.iord, bus.memtoreg, bus.regdst, bus.linkwrite,
            bus.alusrcb, bus.pcsrc, bus.aluop};
  endfunction

  function automatic int nominal_lat(input logic [3:0] op);
    case (op)
      OP_LW:                     return 5;
      OP_SW, OP_ADD, OP_NAND:    return 4;
      OP_BEQ, OP_JAL:            return 3;
      default:                   return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_and_check(input int st, input logic [3:0] op_v);
    if (rq.size() > 0) cur_rdy = 1'(rq.pop_front());
    else if (rnd_mode)  cur_rdy = 1'($urandom_range(0, 1));
    else                cur_rdy = 1'b1;
    bus.op        = op_v;
    bus.mem_ready = cur_rdy;
    #1;
    chk($sformatf("state_in_%0d", st), 16'(bus.state), 16'(st));
    chk($sformatf("ctrl_in_%0d", st), obs_ctrl(), exp_ctrl(st, cur_rdy));
    chk($sformatf("illegal_in_%0d", st), 16'(bus.illegal), 16'(exp_ill));
  endtask

  // Asynchronous reset asserted mid-cycle: effect must be visible at once.
  task automatic async_reset_check();
    #2 reset = 1'b0;
    #1;
    exp_ill = 1'b0;
    chk("rst_state", 16'(bus.state), 16'd0);
    chk("rst_memwrite", 16'(bus.memwrite), 16'd0);
    chk("rst_regwrite", 16'(bus.regwrite), 16'd0);
    chk("rst_ctrl", obs_ctrl(), exp_ctrl(0, cur_rdy));
    chk("rst_illegal", 16'(bus.illegal), 16'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_instr(input logic [3:0] op_dec, input logic [3:0] op_mem,
                           input int exp_lat, input int abort_st);
    int idx, cycles, st;
    bit hold;
    logic [3:0] op_v;
    path.delete();
    path.push_back(0);
    path.push_back(1);
    if (op_dec == OP_LW || op_dec == OP_SW) begin
      path.push_back(2);
      if (op_mem == OP_LW) begin path.push_back(3); path.push_back(4); end
      else if (op_mem == OP_SW) path.push_back(5);
      else path.push_back(10);
    end else if (op_dec == OP_ADD || op_dec == OP_NAND) begin
      path.push_back(6); path.push_back(7);
    end else if (op_dec == OP_BEQ) path.push_back(8);
    else if (op_dec == OP_JAL)     path.push_back(9);
    else                           path.push_back(10);

    idx = 0;
    cycles = 0;
    while (idx < path.size()) begin
      st = path[idx];
      if (st == 10) exp_ill = 1'b1;
      op_v = (st == 1) ? op_dec : (st == 2) ? op_mem : 4'($urandom);
      drive_and_check(st, op_v);
      if (st == abort_st) begin
        async_reset_check();
        return;
      end
      if (st == 10) begin
        if (exp_lat > 0) chk("trap_entry_cycles", 16'(cycles), 16'(exp_lat));
        @(negedge clk);
        return;
      end
      hold = 1'b0;
`ifdef MCCTRL_MEMWAIT_EN
      hold = (st == 0 || st == 3 || st == 5) && !cur_rdy;
`endif
      if (!hold) idx++;
      cycles++;
      if (cycles > 200) begin
        checks++;
        errors++;
        $error("FAIL cycle_budget observed=%0d expected<=200", cycles);
        idx = path.size();
      end
      @(negedge clk);
    end
    if (exp_lat > 0) chk("latency", 16'(cycles), 16'(exp_lat));
  endtask

  task automatic hold_trap(input int n);
    bit save;
    save = rnd_mode;
    rnd_mode = 1'b1;
    repeat (n) begin
      drive_and_check(10, 4'($urandom));
      @(negedge clk);
    end
    rnd_mode = save;
  endtask

  logic [3:0] legal_ops[6]   = '{OP_ADD, OP_NAND, OP_SW, OP_LW, OP_BEQ, OP_JAL};
  logic [3:0] illegal_ops[10] = '{4'b0001, 4'b0011, 4'b0100, 4'b0101, 4'b0110,
                                  4'b0111, 4'b1000, 4'b1100, 4'b1110, 4'b1111};

  initial begin
    logic [3:0] op;
    int lat;
    reset         = 1'b0;
    bus.op        = OP_LW;
    bus.mem_ready = 1'b1;
    cur_rdy       = 1'b1;
    exp_ill       = 1'b0;
    rnd_mode      = 1'b0;

    repeat (3) begin
      @(negedge clk);
      #1;
      chk("reset_state", 16'(bus.state), 16'd0);
      chk("reset_ctrl", obs_ctrl(), exp_ctrl(0, 1'b1));
      chk("reset_illegal", 16'(bus.illegal), 16'd0);
    end
    @(negedge clk);
    reset = 1'b1;

    // Directed instructions, memory always ready.
    run_instr(OP_LW,   OP_LW,   5, -1);
    run_instr(OP_SW,   OP_SW,   4, -1);
    run_instr(OP_JAL,  OP_JAL,  3, -1);
    run_instr(OP_BEQ,  OP_BEQ,  3, -1);
    run_instr(OP_ADD,  OP_ADD,  4, -1);
    run_instr(OP_NAND, OP_NAND, 4, -1);

`ifdef MCCTRL_MEMWAIT_EN
    // LW with 3 wait cycles in FETCH and 2 in MEMRD.
    rq = '{0, 0, 0, 1, 1, 1, 0, 0, 1, 1};
    run_instr(OP_LW, OP_LW, 10, -1);
`endif

    // Random legal instruction stream with random mem_ready.
    rnd_mode = 1'b1;
    repeat (30) begin
      op = legal_ops[$urandom_range(0, 5)];
`ifdef MCCTRL_MEMWAIT_EN
      lat = 0;
`else
      lat = nominal_lat(op);
`endif
      run_instr(op, op, lat, -1);
    end
    rnd_mode = 1'b0;

    // Reset while a store is waiting in MEMWR.
    rq = '{1, 1, 1, 0};
    run_instr(OP_SW, OP_SW, 0, 5);

    // Illegal opcode trap, held, then cleared by reset.
    run_instr(4'b0111, 4'b0000, 2, -1);
    hold_trap(20);
    async_reset_check();

    op = illegal_ops[$urandom_range(0, 9)];
    run_instr(op, 4'b0000, 2, -1);
    hold_trap(3);
    async_reset_check();

    // Opcode changing between DECODE and MEMADR traps from MEMADR.
    run_instr(OP_LW, OP_ADD, 3, -1);
    hold_trap(2);
    async_reset_check();

    run_instr(OP_LW, OP_LW, 5, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
